// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared pipeline types and constants
package pipeline_hazard_ctrl_pkg;

    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int REG_W            = 5;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } ctrlState_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status in, hazard control out
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic             endProgram;
    logic             branchTaken;
    logic             jump;
    logic [REG_W-1:0] idRs1;
    logic [REG_W-1:0] idRs2;
    logic             idUsesRs2;
    logic             exMemRead;
    logic [REG_W-1:0] exRd;
    logic             pcSelect;
    logic             stall;
    logic             flushIfId;
    logic             bubbleIdEx;
    logic             halted;

    modport master (
        output endProgram, branchTaken, jump, idRs1, idRs2, idUsesRs2, exMemRead, exRd,
        input  pcSelect, stall, flushIfId, bubbleIdEx, halted
    );

    modport slave (
        input  endProgram, branchTaken, jump, idRs1, idRs2, idUsesRs2, exMemRead, exRd,
        output pcSelect, stall, flushIfId, bubbleIdEx, halted
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - load-use register compare
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRd,
    input  logic [REG_W-1:0] idRs1,
    input  logic [REG_W-1:0] idRs2,
    input  logic             idUsesRs2,
    output logic             hazard
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hazard = exMemRead && (exRd != '0) &&
                    ((exRd == idRs1) || ((exRd == idRs2) && idUsesRs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - boot/run/drain/halt control with stall and flush
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_hazard_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]        stallCount,
    output logic [CNT_W-1:0]        flushCount
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    ctrlState_t         state, nextState;
    logic [DRAIN_W-1:0] drainCnt, nextDrainCnt;
    logic               hazardLast;
    logic               hazardRaw;
    logic               hazardStall;
    logic               runFlush;
    logic               pcSelect, stall, flushIfId, bubbleIdEx, halted;

    load_use_detect uDetect (
        .exMemRead (bus.exMemRead),
        .exRd      (bus.exRd),
        .idRs1     (bus.idRs1),
        .idRs2     (bus.idRs2),
        .idUsesRs2 (bus.idUsesRs2),
        .hazard    (hazardRaw)
    );

    always_comb begin
        nextState    = state;
        nextDrainCnt = drainCnt;
        pcSelect     = 1'b0;
        stall        = 1'b0;
        flushIfId    = 1'b0;
        bubbleIdEx   = 1'b0;
        halted       = 1'b0;
        hazardStall  = 1'b0;
        runFlush     = 1'b0;
        case (state)
            BOOT: begin
                pcSelect  = 1'b1;
                nextState = RUN;
            end
            RUN: begin
                // The load has moved to MEM after one bubble, so the cycle after a stall is exempt
                if (hazardRaw && !hazardLast) begin
                    hazardStall = 1'b1;
                    stall       = 1'b1;
                    bubbleIdEx  = 1'b1;
                end else if (bus.branchTaken || bus.jump) begin
                    runFlush  = 1'b1;
                    flushIfId = 1'b1;
                end else if (bus.endProgram) begin
                    nextState    = DRAIN;
                    nextDrainCnt = DRAIN_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                stall     = 1'b1;
                flushIfId = 1'b1;
                if (drainCnt == '0) begin
                    nextState = HALT;
                end else begin
                    nextDrainCnt = drainCnt - 1'b1;
                end
            end
            HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: nextState = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            drainCnt   <= '0;
            hazardLast <= 1'b0;
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            state      <= nextState;
            drainCnt   <= nextDrainCnt;
            hazardLast <= hazardStall;
            if (hazardStall && (stallCount != '1)) begin
                stallCount <= stallCount + 1'b1;
            end
            if (runFlush && (flushCount != '1)) begin
                flushCount <= flushCount + 1'b1;
            end
        end
    end

    assign bus.pcSelect   = pcSelect;
    assign bus.stall      = stall;
    assign bus.flushIfId  = flushIfId;
    assign bus.bubbleIdEx = bubbleIdEx;
    assign bus.halted     = halted;

endmodule
